prime_stream: RTL and testbench
===============================

// Module: prime_stream
// PURPOSE
//  Downstream consumer of the isPrime sieve. On start, scans the RANGE-bit primality bitmap (bit i = START+i is prime)
//  from index 0 upward and streams each prime value out over a valid/ready interface.
//  Feeds the UART/display formatter. Replaces the bench-side bitmap walk with synthesizable hardware.
// PARAMETERS
//  RANGE   10000  bitmap width; number of candidates examined
//  START   100    integer value represented by bitmap bit 0
//  NUM_W   14     prime_data width; must hold START+RANGE-1
//  CNT_W   14     prime_count width; must hold RANGE
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        1-cycle pulse: begin a scan (honoured in IDLE/DONE only)
//  result       in   RANGE    sieve bitmap; held stable by producer while busy=1
//  prime_valid  out  1        prime_data holds a prime
//  prime_ready  in   1        consumer accepts when valid&&ready
//  prime_data   out  NUM_W    START+idx of current prime
//  busy         out  1        high in SCAN/EMIT
//  done         out  1        high in DONE until next start or reset
//  prime_count  out  CNT_W    primes accepted by consumer this scan
//  max_gap      out  NUM_W    (PRIME_STREAM_GAP_EN only) largest gap between consecutive emitted primes
// BEHAVIOUR
//  Reset: state=IDLE; idx=0; prime_valid=0; prime_data=0; busy=0; done=0; prime_count=0; max_gap=0. Reset wins over everything, any state.
//  FSM: IDLE -start-> SCAN; SCAN -hit-> EMIT; SCAN -idx==RANGE-1 && !hit-> DONE;
//       EMIT -handshake && idx_last-> DONE; EMIT -handshake-> SCAN; DONE -start-> SCAN.
//  start in IDLE/DONE: idx<=0, prime_count<=0, max_gap<=0, done<=0, go SCAN next cycle. start in SCAN/EMIT ignored.
//  SCAN: one bit per cycle. If result[idx]: prime_data<=START+idx, prime_valid<=1, stay on idx, enter EMIT; else idx<=idx+1.
//  EMIT: prime_valid and prime_data held constant until prime_ready. On handshake: prime_valid<=0, prime_count+=1,
//   idx<=idx+1 (or DONE if idx==RANGE-1). Valid never drops without handshake.
//  Latency: start->first valid = 2+k cycles (k = index of first set bit). Peak throughput 1 prime / 2 cycles.
//  Bit RANGE-1 set: emitted, then DONE after its handshake (no wrap, idx never exceeds RANGE-1).
//  All-zero bitmap: DONE exactly RANGE+1 cycles after start, prime_count=0, prime_valid never asserted.
//  prime_ready while !prime_valid: no effect. Arithmetic unsigned; START+idx computed at NUM_W, no overflow by parameter rule.
// CONFIGURATION
//  PRIME_STREAM_GAP_EN defined: max_gap port present; on each handshake gap = prime_data - last_prime
//   (first prime of scan only seeds last_prime); max_gap<=max(max_gap, gap). Cleared on start/reset.
//  Undefined: max_gap port and last_prime/gap logic absent; all other behaviour identical.
// STRUCTURE
//  prime_pkg: state enum (IDLE, SCAN, EMIT, DONE) as localparams, default NUM_W/CNT_W, clog2 helper.
//  No sub-module: the FSM, index counter and output register fit in one module.
//  Elaboration check: $error if START+RANGE-1 >= 2**NUM_W or RANGE > 2**CNT_W-1.
// TESTING (RANGE=16, START=100 unless stated; bitmap bits 1,3,7,9,13 set = primes 101,103,107,109,113)
//  1 start, ready=1 -> data sequence 101,103,107,109,113; done=1; prime_count=5; first valid 3 cycles after start.
//  2 result=0, start -> valid never high; done 17 cycles after start; prime_count=0.
//  3 ready low 10 cycles at first valid -> prime_data stays 101, valid stays 1; released, stream resumes 103.
//  4 start pulse during EMIT of 107 -> ignored; sequence and count (5) unchanged; done after 113.
//  5 rst asserted while valid=1 on 109 -> next edge-independent: valid=0, busy=0, count=0; new start restarts at 101.
//  6 GAP_EN: scenario 1 -> max_gap=4; bit 15 only (115) -> max_gap=0, count=1; undefined build: max_gap absent.

Source files
------------

// File: rtl/prime_stream_pkg.sv
// rtl/prime_stream_pkg.sv - shared state encoding, default widths and sizing helper for prime_stream
package prime_stream_pkg;

    localparam int DEF_RANGE = 10000;
    localparam int DEF_START = 100;
    localparam int DEF_NUM_W = 14;
    localparam int DEF_CNT_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bits needed to index n entries; never less than one so a 1-wide bitmap still elaborates.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return (r > 0) ? r : 1;
    endfunction

endpackage

// File: rtl/prime_stream.sv
// rtl/prime_stream.sv - walks a sieve bitmap and streams each prime over valid/ready
// Optional max_gap tracking is built when PRIME_STREAM_GAP_EN is defined.
module prime_stream
    import prime_stream_pkg::*;
#(
    parameter int RANGE = DEF_RANGE,
    parameter int START = DEF_START,
    parameter int NUM_W = DEF_NUM_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RANGE-1:0] result,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic [NUM_W-1:0] prime_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] prime_count
`ifdef PRIME_STREAM_GAP_EN
    ,
    output logic [NUM_W-1:0] max_gap
`endif
);

    localparam int IDX_W = clog2_f(RANGE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RANGE - 1);
    localparam logic [NUM_W-1:0] START_N  = NUM_W'(START);

    if (START + RANGE - 1 >= 2 ** NUM_W) begin : g_num_w_check
        $error("prime_stream: NUM_W too narrow for START+RANGE-1");
    end
    if (RANGE > 2 ** CNT_W - 1) begin : g_cnt_w_check
        $error("prime_stream: CNT_W too narrow for RANGE");
    end

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             handshake;
    logic             idx_last;

    assign handshake = prime_valid && prime_ready;
    assign idx_last  = (idx == LAST_IDX);

`ifdef PRIME_STREAM_GAP_EN
    logic [NUM_W-1:0] last_prime;
    logic             have_last;
    logic [NUM_W-1:0] gap;

    assign gap = prime_data - last_prime;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_prime <= '0;
            have_last  <= 1'b0;
            max_gap    <= '0;
        end else if (start && (state == ST_IDLE || state == ST_DONE)) begin
            last_prime <= '0;
            have_last  <= 1'b0;
            max_gap    <= '0;
        end else if (state == ST_EMIT && handshake) begin
            // The first prime of a scan has no predecessor, so it only seeds last_prime.
            last_prime <= prime_data;
            have_last  <= 1'b1;
            if (have_last && gap > max_gap) begin
                max_gap <= gap;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            prime_valid <= 1'b0;
            prime_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            prime_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx         <= '0;
                        prime_count <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (result[idx]) begin
                        prime_data  <= START_N + NUM_W'(idx);
                        prime_valid <= 1'b1;
                        state       <= ST_EMIT;
                    end else if (idx_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_EMIT: begin
                    // prime_valid/prime_data stay frozen here until the consumer takes the value.
                    if (handshake) begin
                        prime_valid <= 1'b0;
                        prime_count <= prime_count + 1'b1;
                        if (idx_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_SCAN;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prime_stream.sv
// tb/tb_prime_stream.sv - scoreboard bench for prime_stream (RANGE=16, START=100)
module tb_prime_stream;

    localparam int RANGE = 16;
    localparam int START = 100;
    localparam int NUM_W = 14;
    localparam int CNT_W = 14;
    localparam logic [RANGE-1:0] BM1 = 16'b0010_0010_1000_1010;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [RANGE-1:0] result = '0;
    logic             prime_valid;
    logic             prime_ready = 1'b0;
    logic [NUM_W-1:0] prime_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] prime_count;
`ifdef PRIME_STREAM_GAP_EN
    logic [NUM_W-1:0] max_gap;
`endif

    prime_stream #(
        .RANGE(RANGE),
        .START(START),
        .NUM_W(NUM_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .result     (result),
        .prime_valid(prime_valid),
        .prime_ready(prime_ready),
        .prime_data (prime_data),
        .busy       (busy),
        .done       (done),
        .prime_count(prime_count)
`ifdef PRIME_STREAM_GAP_EN
        ,
        .max_gap    (max_gap)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_q[$];
    int ready_mode = 1;
    int valid_seen = 0;
    bit hold_pend = 1'b0;
    int hold_data = 0;
    int exp_count = 0;
    int exp_gap = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: primes are simply the set bit positions offset by START, in ascending order.
    task automatic load_model(input logic [RANGE-1:0] bm);
        int prev;
        prev = -1;
        exp_count = 0;
        exp_gap = 0;
        for (int i = 0; i < RANGE; i++) begin
            if (bm[i]) begin
                exp_q.push_back(START + i);
                exp_count++;
                if (prev >= 0 && (START + i - prev) > exp_gap) exp_gap = START + i - prev;
                prev = START + i;
            end
        end
    endtask

    // ready policy: 0 = held low, 1 = always high, other = random with 3/4 duty
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       prime_ready = 1'b0;
                1:       prime_ready = 1'b1;
                default: prime_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (prime_valid) valid_seen++;
                if (hold_pend) begin
                    chk("valid_hold", int'(prime_valid), 1);
                    chk("data_hold", int'(prime_data), hold_data);
                end
                if (prime_valid && prime_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_prime: got %0d, expected none", prime_data);
                    end else begin
                        chk("prime_data", int'(prime_data), exp_q.pop_front());
                    end
                    hold_pend = 1'b0;
                end else if (prime_valid) begin
                    hold_pend = 1'b1;
                    hold_data = int'(prime_data);
                end else begin
                    hold_pend = 1'b0;
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_valid_data(input int d);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!(prime_valid && (d < 0 || int'(prime_data) == d)) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!prime_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_count"}, int'(prime_count), exp_count);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_busy"}, int'(busy), 0);
`ifdef PRIME_STREAM_GAP_EN
        chk({tag, "_max_gap"}, int'(max_gap), exp_gap);
`endif
    endtask

    task automatic run_scan(input string tag, input logic [RANGE-1:0] bm, input int mode);
        ready_mode = mode;
        result = bm;
        load_model(bm);
        pulse_start();
        wait_done();
        @(negedge clk);
        end_checks(tag);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(prime_valid), 0);
        chk("rst_data", int'(prime_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(prime_count), 0);
        rst = 1'b0;

        // basic stream with first-valid latency
        ready_mode = 1;
        result = BM1;
        load_model(BM1);
        @(posedge clk);
        #1 start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1 start = 1'b0;
        end while (!prime_valid && lat < 50);
        chk("first_valid_latency", lat, 3);
        wait_done();
        @(negedge clk);
        end_checks("basic");

        // empty bitmap
        result = '0;
        load_model('0);
        valid_seen = 0;
        @(posedge clk);
        #1 start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1 start = 1'b0;
        end while (!done && lat < 50);
        chk("empty_done_latency", lat, 17);
        chk("empty_valid_seen", valid_seen, 0);
        end_checks("empty");

        // backpressure on the first prime
        ready_mode = 0;
        result = BM1;
        load_model(BM1);
        pulse_start();
        wait_valid_data(-1);
        repeat (10) @(negedge clk);
        chk("stall_data", int'(prime_data), 101);
        chk("stall_valid", int'(prime_valid), 1);
        ready_mode = 1;
        wait_done();
        @(negedge clk);
        end_checks("stall");

        // start during EMIT is ignored
        ready_mode = 1;
        load_model(BM1);
        pulse_start();
        wait_valid_data(107);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        @(negedge clk);
        end_checks("start_in_emit");

        // asynchronous reset mid-stream, then a clean restart
        load_model(BM1);
        pulse_start();
        wait_valid_data(109);
        rst = 1'b1;
        #1;
        chk("midrst_valid", int'(prime_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_count", int'(prime_count), 0);
        chk("midrst_done", int'(done), 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        run_scan("restart", BM1, 1);

        run_scan("last_bit", 16'h8000, 1);
        run_scan("first_bit", 16'h0001, 2);
        run_scan("all_ones", 16'hFFFF, 2);
        for (int i = 0; i < 8; i++) begin
            run_scan("random", RANGE'($urandom), 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
